// File: rtl/mod47_unscale.sv
// Modular unscale: out = (y * KINV) mod MOD, computed by
// an MSB-first Horner loop, one input bit per clock.
module mod47_unscale #(
    parameter int W    = 6,
    parameter int MOD  = 47,
    parameter int KINV = 34
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_err,
    output logic         busy
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(W - 1);
    localparam logic [W:0] MOD_X  = (W + 1)'(MOD);
    localparam logic [W:0] KINV_X = (W + 1)'(KINV);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  acc;
    logic [W-1:0]  y_q;
    logic [CW-1:0] cnt;
    logic [W:0]    dbl;
    logic [W:0]    dbl_red;
    logic [W:0]    sum;
    logic [W:0]    sum_red;
    logic [W-1:0]  acc_nxt;
    logic          y_err;

    assign in_ready  = (state == IDLE);
    assign busy      = (state == BUSY);
    assign out_valid = (state == DONE);

    // One Horner step: acc*2 mod MOD, then add KINV when y[cnt] is set.
    always_comb begin
        dbl     = {acc, 1'b0};
        dbl_red = (dbl >= MOD_X) ? dbl - MOD_X : dbl;
        sum     = dbl_red + KINV_X;
        sum_red = (sum >= MOD_X) ? sum - MOD_X : sum;
        acc_nxt = y_q[cnt] ? sum_red[W-1:0] : dbl_red[W-1:0];
        y_err   = ({1'b0, y_q} >= MOD_X);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; results are never overlapped with new accepts.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid) state_nxt = BUSY;
            BUSY: if (cnt == '0) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, bit counter, accumulator and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            y_q      <= '0;
            cnt      <= '0;
            out_data <= '0;
            out_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        y_q <= in_data;
                        acc <= '0;
                        cnt <= CNT_TOP;
                    end
                end
                BUSY: begin
                    acc <= acc_nxt;
                    if (cnt == '0) begin
                        out_data <= y_err ? '0 : acc_nxt;
                        out_err  <= y_err;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/mod47_unscale.md
MOD47_UNSCALE -- requirements
Module: mod47_unscale

Interface
REQ-001 Parameter W, default 6, residue width in bits.
REQ-002 Parameter MOD, default 47, modulus; MOD SHALL be odd and in the range 3..2^W-1.
REQ-003 Parameter KINV, default 34, inverse scale constant in 0..MOD-1; 34 is the inverse of 300 mod 47, since 300 mod 47 = 18 and 18*34 mod 47 = 1.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 in_valid  input  1  in_data is valid.
REQ-007 in_ready  output  1  block can accept a new operand.
REQ-008 in_data  input  W  scaled residue y.
REQ-009 out_valid  output  1  out_data and out_err are valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_data  output  W  unscaled residue x = (y*KINV) mod MOD.
REQ-012 out_err  output  1  accepted y was >= MOD.
REQ-013 busy  output  1  block is in the BUSY state.

Function
REQ-014 The FSM SHALL have exactly three states:
- IDLE: in_ready=1.
- BUSY: busy=1.
- DONE: out_valid=1.
REQ-015 An input transfer SHALL occur on an edge where the state is IDLE and in_valid=1:
- y is latched.
- acc is cleared to 0.
- The bit counter is loaded with W-1.
- The state moves to BUSY.
REQ-016 In BUSY, each edge SHALL perform one MSB-first Horner step for bit i = counter:
- t = 2*acc; subtract MOD if t >= MOD.
- If y[i]=1, t = t + KINV; subtract MOD if the sum is >= MOD.
- acc = t.
REQ-017 All intermediate sums SHALL be computed at W+1 bits; acc SHALL always remain in 0..MOD-1.
REQ-018 On the BUSY edge where the counter equals 0:
- The state SHALL move to DONE.
- out_data SHALL be loaded with the final acc.
REQ-019 Latency SHALL be fixed:
- out_valid rises exactly W edges (6 by default) after the accepting edge.
- This holds for every input value, including error inputs.
REQ-020 If the latched y >= MOD:
- The W BUSY cycles SHALL still elapse.
- The result SHALL be out_data=0 and out_err=1.
- Otherwise out_err=0.
REQ-021 In DONE:
- out_data and out_err SHALL remain stable until out_ready=1 is sampled.
- On that edge the state returns to IDLE and out_valid deasserts.
REQ-022 in_ready SHALL be 0 in BUSY and DONE; in_valid in those states SHALL be ignored, with no queueing.
REQ-023 A new operand SHALL NOT be accepted on the same edge as a result handshake.
- Minimum throughput is one result per W+2 cycles.
REQ-024 Combinational paths:
- in_ready, out_valid and busy SHALL be decoded from registered state only.
- There SHALL be no combinational path from in_valid or out_ready to any output.
REQ-025 out_data SHALL hold its last value while in IDLE and BUSY; it is don't-care when out_valid=0.

Reset
REQ-026 When rst_n=0 is sampled, the block SHALL reset as follows:
- state = IDLE, acc = 0, counter = 0, latched y = 0.
- out_data = 0, out_err = 0.
- out_valid = 0, busy = 0, in_ready = 1.
REQ-027 Reset asserted in BUSY or DONE SHALL abort the operation and discard the result.
- No out_valid pulse SHALL follow.
REQ-028 Reset SHALL take priority over any simultaneous handshake.
REQ-029 in_ready SHALL be 1 on the first cycle after rst_n returns high.

Verification
REQ-030 Bench scenarios, stimulus -> required response:
- Known values, out_ready held 1: y=18 -> out_data=1; y=1 -> 34; y=0 -> 0; y=46 -> 13; all with out_err=0 and out_valid exactly 6 edges after the accept edge.
- Exhaustive: y=0..46 -> (out_data*18) mod 47 == y for every y; all 47 results are distinct.
- Error inputs: y=47 and y=63 -> out_data=0, out_err=1, same 6-edge latency; the next valid operand y=2 -> 21.
- Backpressure: y=5, out_ready=0 for 10 cycles -> out_data=29 held stable, in_ready=0 throughout, in_valid pulses ignored; out_ready=1 -> one transfer, then IDLE.
- Reset mid-operation: rst_n=0 at BUSY cycle 3 -> all outputs at reset values next cycle, no out_valid; a following y=18 -> 1.
- Back-to-back: in_valid held 1 with y=3 then y=4, out_ready=1 -> results 8 then 42; acceptances are 8 cycles apart; each operand is transferred exactly once.
